// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one icache request in flight and
// buffers {pc, instr} pairs for decode. Optional feature macro: FETCH_BYPASS_EN.
package mmm_pkg;
  localparam int unsigned XLEN = 32;
endpackage

module fetch_stage
  import mmm_pkg::*;
#(
  parameter int unsigned     DEPTH   = 2,
  parameter logic [XLEN-1:0] BOOT_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic            read_req_o,
  output logic            flush_o,
  input  logic [31:0]     instr_i,
  input  logic            read_done_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            r_state, w_state_next;
  logic [XLEN-1:0]   r_pc, w_pc_next;
  logic [31:0]       r_fifo_instr [DEPTH];
  logic [XLEN-1:0]   r_fifo_pc    [DEPTH];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [CntW-1:0]   r_count, w_count_next;

  logic w_empty, w_not_full, w_req, w_done, w_bypass, w_push, w_pop;

  assign w_empty    = (r_count == '0);
  assign w_not_full = (r_count < CntW'(DEPTH));
  // Gated by reset so the interface never sees a request while held in reset.
  assign w_req      = rst_n_i && (r_state == StIdle) && w_not_full && !redirect_i;
  assign w_done     = (r_state == StWait) && read_done_i && !redirect_i;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_empty && w_done;
`else
  assign w_bypass = 1'b0;
`endif

  assign instr_valid_o = (!w_empty || w_bypass) && !redirect_i;
  assign w_pop         = instr_valid_o && instr_ready_i && !w_empty;
  assign w_push        = w_done && !(w_bypass && instr_ready_i);

  assign pc_o       = r_pc;
  assign read_req_o = w_req;
  assign flush_o    = redirect_i;
  assign instr_o    = w_bypass ? instr_i : r_fifo_instr[r_rptr];
  assign instr_pc_o = w_bypass ? r_pc : r_fifo_pc[r_rptr];

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      StIdle: if (w_req) w_state_next = StWait;
      StWait: begin
        if (w_done) begin
          w_state_next = StIdle;
          w_pc_next    = r_pc + XLEN'(4);
        end
      end
      default: w_state_next = StIdle;
    endcase
    if (redirect_i) begin
      w_state_next = StIdle;
      w_pc_next    = redirect_pc_i & ~XLEN'(3);
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) w_count_next = r_count + CntW'(1);
    if (w_pop && !w_push) w_count_next = r_count - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StIdle;
      r_pc    <= BOOT_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
    end else if (redirect_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_push) begin
        r_fifo_instr[r_wptr] <= instr_i;
        r_fifo_pc[r_wptr]    <= r_pc;
        r_wptr               <= r_wptr + PtrW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PtrW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the fetch/decode contract.
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect, read_done, instr_ready;
  logic [31:0] redirect_pc, instr_in;
  logic [31:0] pc_o, instr_o, instr_pc_o;
  logic        read_req_o, flush_o, instr_valid_o;

  fetch_stage #(.DEPTH(DEPTH), .BOOT_PC(32'h0)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc_o),
    .read_req_o    (read_req_o),
    .flush_o       (flush_o),
    .instr_i       (instr_in),
    .read_done_i   (read_done),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Model: current PC, request in flight, and the decode queue of {pc, instr}.
  logic [31:0] m_pc;
  bit          m_busy;
  int          m_k;
  logic [63:0] m_q[$];

  // Cache behaviour knobs.
  int          g_lat = 1;
  bit          g_rand = 1'b0;
  bit          g_fixed = 1'b0;
  logic [31:0] g_instr = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    read_done = 1'b0;
    instr_ready = 1'b0;
    redirect_pc = 32'h0;
    instr_in = 32'h0;
    #1;
    chk("rst_pc", 64'(pc_o), 64'h0);
    chk("rst_req", 64'(read_req_o), 64'h0);
    chk("rst_valid", 64'(instr_valid_o), 64'h0);
    chk("rst_flush", 64'(flush_o), 64'h0);
    chk("rst_instr", 64'(instr_o), 64'h0);
    chk("rst_instr_pc", 64'(instr_pc_o), 64'h0);
    m_q.delete();
    m_pc = 32'h0;
    m_busy = 1'b0;
    m_k = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, advance model.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit ready);
    bit          done, byp, exp_req, exp_valid, done_eff;
    logic [31:0] ins;
    logic [63:0] head;
    if (m_busy) begin
      m_k++;
      done = g_rand ? ($urandom_range(2) == 0) : (m_k >= g_lat);
    end else begin
      done = g_rand ? ($urandom_range(7) == 0) : 1'b0;
    end
    ins = g_fixed ? g_instr : $urandom;
    redirect = redir;
    redirect_pc = rpc;
    read_done = done;
    instr_in = ins;
    instr_ready = ready;
    #1;
    exp_req  = !m_busy && (m_q.size() < DEPTH) && !redir;
    done_eff = m_busy && done && !redir;
`ifdef FETCH_BYPASS_EN
    byp = done_eff && (m_q.size() == 0);
`else
    byp = 1'b0;
`endif
    exp_valid = ((m_q.size() != 0) || byp) && !redir;
    chk("pc", 64'(pc_o), 64'(m_pc));
    chk("req", 64'(read_req_o), 64'(exp_req));
    chk("flush", 64'(flush_o), 64'(redir));
    chk("valid", 64'(instr_valid_o), 64'(exp_valid));
    if (exp_valid) begin
      head = (m_q.size() != 0) ? m_q[0] : {m_pc, ins};
      chk("instr", 64'(instr_o), 64'(head[31:0]));
      chk("instr_pc", 64'(instr_pc_o), 64'(head[63:32]));
    end
    if (redir) begin
      m_q.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
      m_busy = 1'b0;
    end else begin
      if (exp_valid && ready && m_q.size() != 0) void'(m_q.pop_front());
      if (done_eff) begin
        if (!(byp && ready)) m_q.push_back({m_pc, ins});
        m_pc = m_pc + 32'd4;
        m_busy = 1'b0;
      end
      if (exp_req) begin
        m_busy = 1'b1;
        m_k = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Cache answers 0x13 two cycles after each request, decode always ready.
    g_lat = 2;
    g_fixed = 1'b1;
    g_instr = 32'h0000_0013;
    repeat (8) cycle(1'b0, 32'h0, 1'b1);
    g_fixed = 1'b0;

    // Decode stalled with immediate responses: fills to DEPTH, then drains.
    do_reset();
    g_lat = 1;
    repeat (6) cycle(1'b0, 32'h0, 1'b0);
    repeat (6) cycle(1'b0, 32'h0, 1'b1);

    // Redirect to 0x1003 while waiting with one entry buffered.
    do_reset();
    g_lat = 3;
    repeat (5) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0000_1003, 1'b0);
    repeat (4) cycle(1'b0, 32'h0, 1'b0);

    // Redirect landing on the same cycle as read_done.
    do_reset();
    g_lat = 1;
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0000_0200, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b1);

    // Push and pop together with one entry held.
    do_reset();
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
    repeat (5) cycle(1'b0, 32'h0, 1'b1);

    // PC wrap past the top of the address space.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (6) cycle(1'b0, 32'h0, 1'b1);

    // Reset while a request is outstanding.
    cycle(1'b0, 32'h0, 1'b0);
    do_reset();

    g_rand = 1'b1;
    repeat (3000) cycle($urandom_range(29) == 0, $urandom, 1'($urandom_range(1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage, sitting directly upstream of the icache-side handshake interface and downstream of the branch/jump resolution logic.
- Owns the program counter and issues one read request at a time to the interface.
- Collects returned instructions into a small FIFO and hands {pc, instr} pairs to decode over a valid/ready handshake.
- Handles control-flow redirects by flushing its FIFO and the interface.

Parameters:
- DEPTH, 2, fetch FIFO entries; power of two, >= 2.
- BOOT_PC, 'h0000_0000 (XLEN bits, XLEN from mmm_pkg), PC value after reset; bits [1:0] must be 0.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- redirect_i  in  1  control-flow redirect, single-cycle pulse.
- redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored (treated as 0).
- pc_o  out  XLEN  fetch address to interface; equals PC register.
- read_req_o  out  1  request pulse to interface.
- flush_o  out  1  flush to interface; equals redirect_i, combinational.
- instr_i  in  32  instruction word returned by interface.
- read_done_i  in  1  instr_i valid this cycle.
- instr_o  out  32  instruction to decode.
- instr_pc_o  out  XLEN  PC of instr_o.
- instr_valid_o  out  1  decode-side valid.
- instr_ready_i  in  1  decode-side ready.

Behaviour:
- Reset values (async, rst_n_i low):
  - PC = BOOT_PC; state = IDLE; FIFO count = 0, pointers = 0.
  - read_req_o = 0, instr_valid_o = 0, flush_o = 0; instr_o and instr_pc_o = 0.
- Single outstanding request; FSM states IDLE and WAIT.
- IDLE:
  - read_req_o = 1 iff count < DEPTH and !redirect_i.
  - On read_req_o = 1, next state is WAIT.
- WAIT:
  - read_req_o = 0.
  - On read_done_i: push {PC, instr_i}, PC <= PC + 4 (mod 2^XLEN, wraps silently), state <= IDLE.
  - Otherwise stay in WAIT.
- pc_o = PC register; stable from request until read_done_i, because the interface drives its address from it combinationally.
- Request-to-FIFO latency:
  - Next request issues the cycle after read_done_i (IDLE), provided the FIFO is not full.
  - Minimum 1 issued request per 2 cycles plus cache latency.
- Overflow is impossible: a request is only issued when there is space for its response.
- Decode side:
  - instr_valid_o = (count != 0) && !redirect_i.
  - Pop when instr_valid_o && instr_ready_i; head presented on instr_o / instr_pc_o.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Empty: instr_valid_o = 0.
  - Full: no new request issued; the outstanding response still fits because of the space check.
- Redirect (redirect_i = 1), in any state:
  - flush_o = 1 in the same cycle.
  - FIFO cleared (count and pointers to 0) at the clock edge.
  - PC <= {redirect_pc_i[XLEN-1:2], 2'b00}; state <= IDLE.
  - A read_done_i in the same cycle is discarded (no push, no PC increment).
  - No pop occurs in that cycle.
  - First request to the new PC issues the cycle after the redirect.
- read_done_i in IDLE (spurious) is ignored.
- Reset mid-transaction returns all state to reset values immediately; no pending request survives.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When the FIFO is empty and read_done_i = 1 in WAIT (no redirect), instr_o / instr_pc_o / instr_valid_o are driven directly from instr_i / PC in the same cycle.
  - If instr_ready_i = 1, the entry is consumed and not pushed; otherwise it is pushed as normal.
  - Latency read_done_i -> instr_valid_o is 0 cycles.
- Not defined: responses are always pushed; instr_valid_o asserts 1 cycle after read_done_i.

Test Plan:
- Reset release, cache returns 32'h0000_0013 two cycles after request, instr_ready_i = 1:
  - pc_o = 'h0 and read_req_o = 1 on the first cycle.
  - instr_o = 'h13 with instr_pc_o = 'h0; next pc_o = 'h4.
  - Latency per the bypass setting.
- instr_ready_i = 0, DEPTH = 2, cache responds immediately:
  - Exactly 2 requests (PCs 0, 4); read_req_o stays 0 while full.
  - Raise ready: pops in order 0, 4; a request to 'h8 issues once count < 2.
- redirect_i with redirect_pc_i = 'h1003 while in WAIT and the FIFO holds 1 entry:
  - flush_o = 1 that cycle; instr_valid_o = 0 that cycle and the next.
  - Next request uses pc_o = 'h1000.
- redirect_i coincident with read_done_i:
  - Response not pushed; PC becomes the redirect target, not old PC + 4.
- Simultaneous push and pop with count = 1: count stays 1; order preserved.
- PC = 'hFFFF_FFFC fetch completes: next pc_o = 'h0 (wrap).
